// File: rtl/mul16_seq_ctrl_pkg.sv
// mul16_seq_ctrl_pkg: state encoding and sizing constants for the nibble-serial multiplier
package mul16_seq_ctrl_pkg;
  localparam int OP_W = 16;
  localparam int NIB_W = 4;
  localparam int N_STEPS = 16;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mul16_seq_ctrl_mul4.sv
// Multiplier4bit: combinational 4x4 unsigned nibble multiplier
module Multiplier4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  assign p = {4'd0, a} * {4'd0, b};
endmodule

// File: rtl/mul16_seq_ctrl.sv
// mul16_seq_ctrl: 16x16 unsigned multiplier, one nibble product per cycle over 16 steps
module mul16_seq_ctrl
  import mul16_seq_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] product,
  output logic        busy
);
  state_t state_q, state_d;
  logic [OP_W-1:0] a_q, a_d, b_q, b_d;
  logic [2*OP_W-1:0] acc_q, acc_d;
  logic [3:0] idx_q, idx_d;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;
  logic [NIB_W-1:0] a_nib, b_nib;
  logic [2*NIB_W-1:0] nib_p;
  logic [2:0] nib_sum;
  logic [4:0] shamt;
  assign a_nib = a_q[{idx_q[1:0], 2'b00} +: NIB_W];
  assign b_nib = b_q[{idx_q[3:2], 2'b00} +: NIB_W];
  assign nib_sum = {1'b0, idx_q[1:0]} + {1'b0, idx_q[3:2]};
  assign shamt = {nib_sum, 2'b00};
  Multiplier4bit u_mul4 (
    .a(a_nib),
    .b(b_nib),
    .p(nib_p)
  );
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    idx_d = idx_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = MUL;
        a_d = a;
        b_d = b;
        acc_d = '0;
        idx_d = '0;
      end
      MUL: begin
        acc_d = acc_q + ({24'd0, nib_p} << shamt);
        idx_d = idx_q + 4'd1;
        state_d = (idx_q == 4'(N_STEPS - 1)) ? DONE : MUL;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    in_ready_d = state_d == IDLE;
    out_valid_d = state_d == DONE;
    busy_d = state_d == MUL;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      idx_q <= '0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      idx_q <= idx_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q <= busy_d;
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy = busy_q;
  assign product = acc_q;
endmodule

// File: tb/tb_mul16_seq_ctrl.sv
// tb_mul16_seq_ctrl: directed table vectors plus stall, reset-abort and ignored-pulse sequences
module tb_mul16_seq_ctrl;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic [15:0] a, b;
  logic in_ready, out_valid, busy;
  logic [31:0] product;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  mul16_seq_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; accepts on the next posedge, scrambles a/b afterwards.
  task automatic do_op(input logic [15:0] va, input logic [15:0] vb, input logic [31:0] vp,
                       input int stall, input bit poke);
    int k;
    int busy_cnt;
    logic [31:0] held;
    in_valid = 1'b1;
    a = va;
    b = vb;
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    out_ready = (stall == 0);
    k = 0;
    busy_cnt = 0;
    while (!out_valid && k < 40) begin
      busy_cnt += busy;
      chk("in_ready_low_in_mul", {31'd0, in_ready}, 32'd0);
      in_valid = poke && (k == 5);
      if (poke && k == 5) begin
        a = 16'h1111;
        b = 16'h1111;
      end
      @(negedge clk);
      k++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(k), 32'd16);
    chk("busy_cycles", 32'(busy_cnt), 32'd16);
    chk("product", product, vp);
    chk("busy_low_in_done", {31'd0, busy}, 32'd0);
    held = product;
    for (int i = 0; i < stall; i++) begin
      in_valid = poke && (i == 0);
      if (poke && i == 0) begin
        a = 16'h1111;
        b = 16'h1111;
      end
      @(negedge clk);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_product", product, held);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    chk("product_after_done", product, vp);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[1] = '{16'h1234, 16'h5678, 32'h06260060};
    vecs[2] = '{16'h0000, 16'hABCD, 32'h00000000};
    vecs[3] = '{16'h8000, 16'h0002, 32'h00010000};
    vecs[4] = '{16'h00F0, 16'h0F00, 32'h000E1000};
    vecs[5] = '{16'h0001, 16'hFFFF, 32'h0000FFFF};
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    a = 16'h1234;
    b = 16'h1234;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_product", product, 32'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) do_op(vecs[i].a, vecs[i].b, vecs[i].p, 0, 1'b0);
    do_op(16'h00FF, 16'h0100, 32'h0000FF00, 5, 1'b0);
    do_op(16'h1111, 16'h1111, 32'h01234321, 2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_extra_accept_busy", {31'd0, busy}, 32'd0);
      chk("no_extra_out_valid", {31'd0, out_valid}, 32'd0);
    end
    in_valid = 1'b1;
    a = 16'h8000;
    b = 16'h0002;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_product", product, 32'd0);
    rst = 1'b0;
    do_op(16'h0003, 16'h0005, 32'h0000000F, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("abort_no_out_valid", {31'd0, out_valid}, 32'd0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul16_seq_ctrl.md
MUL16_SEQ_CTRL -- requirements
Module: mul16_seq_ctrl

Interface
Parameters: none; operand width is fixed at 16 bits.
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port in_valid, input, 1 bit: operands a and b are presented.
REQ-004 The block SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-005 The block SHALL have port a, input, 16 bits: unsigned multiplicand.
REQ-006 The block SHALL have port b, input, 16 bits: unsigned multiplier.
REQ-007 The block SHALL have port out_valid, output, 1 bit: product is valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the consumer takes the product.
REQ-009 The block SHALL have port product, output, 32 bits: unsigned a*b.
REQ-010 The block SHALL have port busy, output, 1 bit: high while in state MUL.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, MUL, DONE.
REQ-012 in_ready SHALL be 1 only in IDLE, out_valid SHALL be 1 only in DONE, and busy SHALL be 1 only in MUL.
REQ-013 An accept SHALL occur on a rising edge where the state is IDLE and in_valid=1, and SHALL:
- latch a and b into internal registers;
- clear the 32-bit accumulator;
- set the 4-bit step counter idx to 0;
- move the FSM to MUL.
REQ-014 In IDLE with in_valid=0, the state SHALL be unchanged.
REQ-015 In MUL, each rising edge SHALL perform one step:
- i = idx[1:0] and j = idx[3:2];
- form the 8-bit nibble product of a_reg[4i+3:4i] and b_reg[4j+3:4j];
- zero-extend it to 32 bits, shift it left by 4*(i+j), and add it to the accumulator;
- increment idx.
REQ-016 The 16 nibble products SHALL be computed over 16 consecutive MUL cycles, with idx going 0 to 15 in order.
REQ-017 The accumulator addition SHALL be 32-bit and SHALL discard any carry out; a 16x16 result fits in 32 bits, so no overflow handling is required.
REQ-018 On the edge that processes idx=15, idx SHALL wrap to 0 and the FSM SHALL move to DONE.
REQ-019 out_valid SHALL rise exactly 16 clocks after the accepting edge; latency is 16 cycles.
REQ-020 Throughput SHALL be one product per 18 cycles minimum (accept, 16 MUL cycles, DONE with out_ready=1).
REQ-021 product SHALL be driven from the accumulator register, with no combinational path from the inputs.
REQ-022 product SHALL be stable for as long as out_valid=1.
REQ-023 In DONE, with out_ready=1 the FSM SHALL move to IDLE on the next edge; with out_ready=0 it SHALL hold DONE indefinitely.
REQ-024 in_valid asserted while the state is MUL or DONE SHALL be ignored, and a, b SHALL have no effect on the operation in progress.
REQ-025 Changes on a and b after the accept SHALL NOT affect the result.
REQ-026 out_ready asserted outside DONE SHALL have no effect.
REQ-027 Operands of 0 SHALL still take the full 16 MUL cycles; there is no early termination.

Reset
REQ-028 When rst=1 at a rising edge, the state SHALL become IDLE and idx and the accumulator SHALL become 0, regardless of the current state.
REQ-029 The reset values of the outputs SHALL therefore be: in_ready=1, out_valid=0, busy=0, product=0x00000000.
REQ-030 Reset SHALL take priority over accept, step and output handshake on the same edge.
REQ-031 A reset in the middle of an operation SHALL abandon that operation and produce no out_valid for it.
REQ-032 The first edge after rst deasserts SHALL be able to accept new operands.

Structure
REQ-033 A shared package SHALL hold:
- the state encoding IDLE=2'd0, MUL=2'd1, DONE=2'd2 (2'd3 is illegal and SHALL recover to IDLE);
- the constants OP_W=16, NIB_W=4, N_STEPS=16.
REQ-034 The block SHALL instantiate exactly one existing Multiplier4bit as the shared nibble-product datapath; no other multiplier is permitted.
REQ-035 The selection of operand nibbles, the shifter and the accumulator SHALL be local logic in the block.

Verification
REQ-036 Scenario: accept a=0xFFFF, b=0xFFFF with out_ready=1 -> out_valid rises 16 clocks after accept with product=0xFFFE0001, and in_ready returns 1 one clock later.
REQ-037 Scenario: a=0x1234, b=0x5678 -> product=0x06260060, and busy is high for exactly 16 cycles.
REQ-038 Scenario: a=0x0000, b=0xABCD -> product=0x00000000 after the full 16-cycle latency.
REQ-039 Scenario: a=0x00FF, b=0x0100, out_ready held 0 for 5 cycles after out_valid -> product=0x0000FF00 held stable, in_ready=0 throughout, and the FSM returns to IDLE one edge after out_ready=1.
REQ-040 Scenario: accept a=0x8000, b=0x0002; assert rst at idx=7; then accept a=0x0003, b=0x0005 -> no out_valid for the first operation and product=0x0000000F for the second.
REQ-041 Scenario: pulse in_valid with a=0x1111, b=0x1111 during MUL and during DONE -> the pulses are ignored, the current result is correct, and exactly one out_valid occurs per accept.
